ped_signal_ctrl: RTL and testbench

Pedestrian crossing controller sitting directly downstream of the vehicle traffic-light controller: it consumes the one-hot green/yellow/red light outputs plus a raw push-button, and drives the walk / don't-walk lamps and a countdown digit. A walk phase is granted only inside a vehicle red phase, and only if a debounced request is pending. Any inconsistency between the vehicle lights and the walk phase forces don't-walk and raises a fault pulse.

---
 rtl/ped_signal_ctrl_pkg.sv | 29 ++
 rtl/ped_signal_ctrl_debounce.sv | 53 +++++
 rtl/ped_signal_ctrl.sv | 126 ++++++++++++
 tb/tb_ped_signal_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ped_signal_ctrl_pkg.sv
// Shared types and default timing for the vehicle and pedestrian controllers.
// Both controllers take their phase lengths from here so red time stays consistent.
package ped_signal_ctrl_pkg;

   typedef enum logic [1:0] {
      VEH_GREEN,
      VEH_YELLOW,
      VEH_RED
   } veh_light_t;

   typedef enum logic [1:0] {
      DONT_WALK,
      WALK,
      FLASH
   } ped_state_t;

   localparam int GREEN_TIME     = 10;
   localparam int YELLOW_TIME    = 3;
   localparam int RED_TIME       = 7;
   localparam int WALK_TIME_DEF  = 3;
   localparam int FLASH_TIME_DEF = 3;
   localparam int DEBOUNCE_DEF   = 3;
   localparam int CNT_W_DEF      = 4;

   function automatic logic one_hot3(input logic [2:0] v);
      return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
   endfunction

endpackage

// File: rtl/ped_signal_ctrl_debounce.sv
// Push-button synchronizer and debouncer.
// flip_o marks the cycle whose closing edge toggles the debounced level.
module btn_debounce #(
   parameter int DEBOUNCE = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic level_o,
   output logic flip_o
);

   localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q;
   logic          level_d;
   logic [DW-1:0] cnt_q;
   logic [DW-1:0] cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   // Count consecutive samples that disagree with the current level.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      flip_o  = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == DW'(DEBOUNCE - 1)) begin
            flip_o  = 1'b1;
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/ped_signal_ctrl.sv
// Pedestrian crossing controller slaved to the vehicle light controller.
// Walk is granted only inside a vehicle red phase; any inconsistency forces don't-walk.
module ped_signal_ctrl
   import ped_signal_ctrl_pkg::*;
#(
   parameter int WALK_TIME  = WALK_TIME_DEF,
   parameter int FLASH_TIME = FLASH_TIME_DEF,
   parameter int DEBOUNCE   = DEBOUNCE_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             green_in,
   input  logic             yellow_in,
   input  logic             red_in,
   input  logic             btn,
   output logic             walk,
   output logic             dont_walk,
   output logic             flash,
   output logic             req_pending,
   output logic [CNT_W-1:0] countdown,
   output logic             fault
);

   ped_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req_q, req_d;
   logic             red_prev_q;
   logic             blink_q, blink_d;
   logic             fault_q, fault_d;

   logic deb_level;
   logic deb_flip;
   logic deb_rise;
   logic red_rise;
   logic fault_cond;

   btn_debounce #(
      .DEBOUNCE(DEBOUNCE)
   ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .btn    (btn),
      .level_o(deb_level),
      .flip_o (deb_flip)
   );

   assign deb_rise   = deb_flip & ~deb_level;
   assign red_rise   = red_in & ~red_prev_q;
   assign fault_cond = ((state_q != DONT_WALK) & ~red_in) |
                       ~one_hot3({green_in, yellow_in, red_in});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= DONT_WALK;
         cnt_q      <= '0;
         req_q      <= 1'b0;
         red_prev_q <= 1'b1;
         blink_q    <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_q      <= req_d;
         red_prev_q <= red_in;
         blink_q    <= blink_d;
         fault_q    <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      blink_d = blink_q;
      fault_d = 1'b0;
      if (deb_rise && state_q != WALK) begin
         req_d = 1'b1;
      end
      if (fault_cond) begin
         state_d = DONT_WALK;
         cnt_d   = '0;
         fault_d = 1'b1;
      end else begin
         unique case (state_q)
            DONT_WALK: begin
               // registered request only: a same-edge press waits for next red
               if (red_rise && req_q) begin
                  state_d = WALK;
                  cnt_d   = CNT_W'(WALK_TIME - 1);
                  req_d   = 1'b0;
               end
            end
            WALK: begin
               if (cnt_q == '0) begin
                  state_d = FLASH;
                  cnt_d   = CNT_W'(FLASH_TIME - 1);
                  blink_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            FLASH: begin
               blink_d = ~blink_q;
               if (cnt_q == '0) begin
                  state_d = DONT_WALK;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: begin
               state_d = DONT_WALK;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign walk        = (state_q == WALK) & red_in;
   assign flash       = (state_q == FLASH);
   assign dont_walk   = (state_q == FLASH) ? blink_q : (state_q != WALK);
   assign req_pending = req_q;
   assign countdown   = flash ? cnt_q + 1'b1 : '0;
   assign fault       = fault_q;

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Directed bench for ped_signal_ctrl.
// Expected values are hand-derived from the vehicle light sequence.
module tb_ped_signal_ctrl;

   logic       clk;
   logic       rst;
   logic       green_in;
   logic       yellow_in;
   logic       red_in;
   logic       btn;
   logic       walk;
   logic       dont_walk;
   logic       flash;
   logic       req_pending;
   logic [3:0] countdown;
   logic       fault;

   int tests = 0;
   int fails = 0;

   bit       walk_e [7] = '{0, 1, 1, 1, 0, 0, 0};
   bit       dw_e   [7] = '{1, 0, 0, 0, 1, 0, 1};
   bit       fl_e   [7] = '{0, 0, 0, 0, 1, 1, 1};
   bit [3:0] cd_e   [7] = '{0, 0, 0, 0, 3, 2, 1};

   ped_signal_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .green_in   (green_in),
      .yellow_in  (yellow_in),
      .red_in     (red_in),
      .btn        (btn),
      .walk       (walk),
      .dont_walk  (dont_walk),
      .flash      (flash),
      .req_pending(req_pending),
      .countdown  (countdown),
      .fault      (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lights(input logic g, input logic y, input logic r);
      green_in  = g;
      yellow_in = y;
      red_in    = r;
   endtask

   task automatic run(input logic g, input logic y, input logic r,
                      input int n);
      lights(g, y, r);
      repeat (n) tick();
   endtask

   task automatic idle_chk(input string tag, input logic g, input logic y,
                           input logic r, input int n);
      for (int i = 0; i < n; i++) begin
         lights(g, y, r);
         #1;
         chk({tag, "_walk"}, walk, 0);
         chk({tag, "_dw"}, dont_walk, 1);
         chk({tag, "_fault"}, fault, 0);
         tick();
      end
   endtask

   task automatic press_green(input string tag);
      btn = 1'b1;
      run(1, 0, 0, 6);
      btn = 1'b0;
      chk({tag, "_req"}, req_pending, 1);
      run(1, 0, 0, 4);
   endtask

   task automatic red_served(input string tag, input bit flash_press);
      for (int k = 0; k < 7; k++) begin
         lights(0, 0, 1);
         if (flash_press) btn = (k <= 5);
         #1;
         chk({tag, "_walk"}, walk, walk_e[k]);
         chk({tag, "_dw"}, dont_walk, dw_e[k]);
         chk({tag, "_flash"}, flash, fl_e[k]);
         chk({tag, "_cd"}, countdown, cd_e[k]);
         chk({tag, "_req"}, req_pending,
             (k == 0) || (flash_press && k >= 5));
         tick();
      end
      lights(1, 0, 0);
      #1;
      chk({tag, "_end_dw"}, dont_walk, 1);
      chk({tag, "_end_flash"}, flash, 0);
   endtask

   initial begin
      rst = 1'b1;
      btn = 1'b0;
      lights(1, 0, 0);
      #1;
      chk("rst_walk", walk, 0);
      chk("rst_dw", dont_walk, 1);
      chk("rst_flash", flash, 0);
      chk("rst_req", req_pending, 0);
      chk("rst_cd", countdown, 0);
      chk("rst_fault", fault, 0);
      tick();
      tick();
      rst = 1'b0;

      for (int v = 0; v < 3; v++) begin
         idle_chk("idle_g", 1, 0, 0, 10);
         idle_chk("idle_y", 0, 1, 0, 3);
         idle_chk("idle_r", 0, 0, 1, 7);
      end

      // press latency: pending on the fifth edge after first sample
      btn = 1'b1;
      lights(1, 0, 0);
      repeat (4) tick();
      chk("lat_edge4", req_pending, 0);
      tick();
      chk("lat_edge5", req_pending, 1);
      tick();
      btn = 1'b0;
      run(1, 0, 0, 4);
      run(0, 1, 0, 3);
      red_served("serve", 0);
      chk("serve_req_clr", req_pending, 0);

      run(1, 0, 0, 2);
      btn = 1'b1;
      run(1, 0, 0, 2);
      btn = 1'b0;
      run(1, 0, 0, 6);
      chk("glitch_req", req_pending, 0);
      run(0, 1, 0, 3);
      idle_chk("glitch_r", 0, 0, 1, 7);

      press_green("walkp");
      run(0, 1, 0, 1);
      btn = 1'b1;
      run(0, 1, 0, 2);
      red_served("walkp", 0);
      btn = 1'b0;
      chk("walkp_req_after", req_pending, 0);
      run(1, 0, 0, 6);

      press_green("flashp");
      run(0, 1, 0, 3);
      red_served("flashp", 1);
      chk("flashp_req_after", req_pending, 1);
      run(1, 0, 0, 10);
      run(0, 1, 0, 3);
      red_served("flashp2", 0);

      press_green("redlo");
      run(0, 1, 0, 3);
      run(0, 0, 1, 3);
      chk("redlo_walk_pre", walk, 1);
      lights(1, 0, 0);
      #1;
      chk("redlo_walk_now", walk, 0);
      chk("redlo_fault_now", fault, 0);
      tick();
      chk("redlo_fault", fault, 1);
      chk("redlo_dw", dont_walk, 1);
      chk("redlo_flash", flash, 0);
      tick();
      chk("redlo_fault_clr", fault, 0);

      lights(1, 0, 1);
      #1;
      chk("gr_fault_now", fault, 0);
      tick();
      chk("gr_fault", fault, 1);
      chk("gr_dw", dont_walk, 1);
      lights(1, 0, 0);
      tick();
      chk("gr_fault_clr", fault, 0);

      run(1, 0, 0, 4);
      press_green("rstf");
      run(0, 1, 0, 3);
      run(0, 0, 1, 4);
      #1;
      chk("rstf_flash_pre", flash, 1);
      chk("rstf_cd_pre", countdown, 3);
      rst = 1'b1;
      #1;
      chk("rstf_walk", walk, 0);
      chk("rstf_dw", dont_walk, 1);
      chk("rstf_flash", flash, 0);
      chk("rstf_req", req_pending, 0);
      chk("rstf_cd", countdown, 0);
      chk("rstf_fault", fault, 0);
      tick();
      tick();
      rst = 1'b0;
      btn = 1'b1;
      run(0, 0, 1, 6);
      btn = 1'b0;
      chk("rstf_req_new", req_pending, 1);
      idle_chk("rstf_nowalk", 0, 0, 1, 4);
      run(1, 0, 0, 3);
      run(0, 1, 0, 3);
      red_served("rstf_next", 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
